bnn_upsample_stream: RTL and testbench

Streaming 2x nearest-neighbour upsampler for binary feature maps. It is the inverse-direction companion of the 2x2 binary max-pool stage. The block accepts one IMG_IN_SIZE-bit input row per valid/ready beat and horizontally duplicates every pixel. Each expanded row is emitted twice, so one frame of IMG_IN_SIZE rows becomes IMG_OUT_SIZE rows of IMG_OUT_SIZE bits. It sits between a row-serial feature source (row buffer or DMA) and a row-serial consumer in the BNN datapath.

---
 rtl/bnn_upsample_stream.sv | 114 +++++++++++
 tb/tb_bnn_upsample_stream.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_upsample_stream.sv
// Streaming 2x nearest-neighbour upsampler for binary feature maps.
// Each input row is widened by pixel duplication and emitted twice.
module bnn_upsample_stream #(
    parameter int IMG_IN_SIZE  = 14,
    parameter int IMG_OUT_SIZE = 2 * IMG_IN_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [IMG_IN_SIZE-1:0]  in_row,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [IMG_OUT_SIZE-1:0] out_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    frame_done
);

    localparam int RW = (IMG_IN_SIZE > 2) ? $clog2(IMG_IN_SIZE) : 1;
    localparam logic [RW-1:0] LAST = RW'(IMG_IN_SIZE - 1);

    if (IMG_OUT_SIZE != 2 * IMG_IN_SIZE || IMG_IN_SIZE < 2) begin : g_bad_param
        $error("bnn_upsample_stream: illegal IMG_IN_SIZE/IMG_OUT_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE,
        EMIT0,
        EMIT1
    } state_t;

    state_t                 state;
    logic [IMG_IN_SIZE-1:0] row_buf;
    logic [RW-1:0]          rcnt;
    logic                   in_hs;
    logic                   out_hs;
    logic                   at_last;

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready && !clear;
    assign at_last = (rcnt == LAST);

    // in_ready follows out_ready in EMIT1 so a new row can slip in back-to-back
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = !clear;
            EMIT1:   in_ready = out_ready && !clear;
            default: in_ready = 1'b0;
        endcase
    end

    for (genvar c = 0; c < IMG_IN_SIZE; c++) begin : g_expand
        assign out_row[2*c]   = row_buf[c];
        assign out_row[2*c+1] = row_buf[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_buf    <= '0;
            rcnt       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            row_buf    <= '0;
            rcnt       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        row_buf   <= in_row;
                        state     <= EMIT0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                EMIT0: begin
                    if (out_hs) begin
                        state    <= EMIT1;
                        out_last <= at_last;
                    end
                end
                EMIT1: begin
                    if (out_hs) begin
                        rcnt       <= at_last ? '0 : rcnt + 1'b1;
                        frame_done <= at_last;
                        out_last   <= 1'b0;
                        if (in_hs) begin
                            row_buf <= in_row;
                            state   <= EMIT0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_upsample_stream.sv
// Self-checking bench for bnn_upsample_stream at IMG_IN_SIZE=4,
// driven by random streams against a queue-based reference model.
module tb_bnn_upsample_stream;

    localparam int N = 4;
    localparam int M = 2 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic [N-1:0] in_row;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] out_row;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         frame_done;

    bnn_upsample_stream #(.IMG_IN_SIZE(N), .IMG_OUT_SIZE(M)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_row     (in_row),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] row;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] src[$];
    logic [M-1:0] got_q[$];
    int           acc;
    bit           fd_pend;
    int           n_chk;
    int           n_fail;

    function automatic logic [M-1:0] expand(input logic [N-1:0] r);
        logic [M-1:0] e;
        for (int c = 0; c < N; c++) begin
            e[2*c]   = r[c];
            e[2*c+1] = r[c];
        end
        return e;
    endfunction

    function automatic void model_accept(input logic [N-1:0] r);
        exp_t e;
        e.row  = expand(r);
        e.last = 1'b0;
        exp_q.push_back(e);
        e.last = (acc == N - 1);
        exp_q.push_back(e);
        acc = (acc + 1) % N;
    endfunction

    task automatic run_stream(input int vpct, input int rpct, output int cycles);
        int   sent;
        bit   exp_ir;
        bit   prev_stall;
        logic [M-1:0] prev_row;
        logic prev_last;
        sent = 0;
        cycles = 0;
        prev_stall = 0;
        prev_row = '0;
        prev_last = 1'b0;
        got_q.delete();
        while ((sent < src.size() || exp_q.size() != 0 || fd_pend) && cycles < 2000) begin
            in_valid  = (sent < src.size()) && ($urandom_range(99) < vpct);
            in_row    = in_valid ? src[sent] : N'($urandom);
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            n_chk++;
            if (frame_done !== fd_pend) begin
                n_fail++;
                $display("FAIL frame_done: got %b want %b", frame_done, fd_pend);
            end
            exp_ir = (exp_q.size() == 0) ? 1'b1 :
                     (exp_q.size() == 1) ? out_ready : 1'b0;
            n_chk++;
            if (in_ready !== exp_ir) begin
                n_fail++;
                $display("FAIL in_ready: got %b want %b", in_ready, exp_ir);
            end
            n_chk++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                n_chk++;
                if (out_row !== exp_q[0].row || out_last !== exp_q[0].last) begin
                    n_fail++;
                    $display("FAIL out_row/last: got %h/%b want %h/%b",
                             out_row, out_last, exp_q[0].row, exp_q[0].last);
                end
            end
            if (prev_stall) begin
                n_chk++;
                if (out_row !== prev_row || out_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h/%b want %h/%b",
                             out_row, out_last, prev_row, prev_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_row   = out_row;
            prev_last  = out_last;
            fd_pend    = 0;
            if (exp_q.size() != 0 && out_ready) begin
                fd_pend = exp_q[0].last;
                got_q.push_back(exp_q[0].row);
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_ir) begin
                model_accept(src[sent]);
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (cycles >= 2000) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d cycles want < 2000", cycles);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0 ||
            in_ready !== 1'b1 || out_row !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v%b l%b fd%b ir%b row%h want v0 l0 fd0 ir1 row00",
                     out_valid, out_last, frame_done, in_ready, out_row);
        end
    endtask

    task automatic test_single();
        int cyc;
        logic [M-1:0] want;
        want = 8'b1100_1100;
        in_valid  = 1'b1;
        in_row    = 4'b1010;
        out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got ir%b v%b want ir1 v0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_row !== want || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_copy0: got v%b %h l%b want v1 %h l0",
                     out_valid, out_row, out_last, want);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_row !== want) begin
            n_fail++;
            $display("FAIL single_copy1: got v%b %h want v1 %h", out_valid, out_row, want);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_back: got v%b ir%b want v0 ir1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        acc = 1;
        src.delete();
        for (int i = 0; i < N - 1; i++) src.push_back(N'($urandom));
        run_stream(100, 100, cyc);
    endtask

    task automatic test_frame();
        int cyc;
        logic [M-1:0] want[8];
        want = '{8'h03, 8'h03, 8'h0C, 8'h0C, 8'h30, 8'h30, 8'hC0, 8'hC0};
        src = '{4'h1, 4'h2, 4'h4, 4'h8};
        run_stream(100, 100, cyc);
        n_chk++;
        if (cyc !== 10) begin
            n_fail++;
            $display("FAIL frame_cycles: got %0d want 10", cyc);
        end
        n_chk++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL frame_count: got %0d want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (got_q[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL frame_row%0d: got %h want %h", i, got_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        src.delete();
        for (int i = 0; i < 2 * N; i++) src.push_back(N'($urandom));
        run_stream(60, 25, cyc);
        src.delete();
        for (int i = 0; i < 3 * N; i++) src.push_back(N'($urandom));
        run_stream(80, 55, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        src.delete();
        for (int i = 0; i < 2 * N; i++) src.push_back(N'($urandom));
        run_stream(100, 100, cyc);
        n_chk++;
        if (cyc !== 4 * N + 2) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d want %0d", cyc, 4 * N + 2);
        end
    endtask

    task automatic test_clear();
        int cyc;
        src = '{4'h3, 4'h9};
        run_stream(100, 100, cyc);
        in_valid  = 1'b1;
        in_row    = 4'h6;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_row   = 4'h5;
        clear    = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== expand(4'h6)) begin
            n_fail++;
            $display("FAIL clear_cycle: got ir%b v%b %h want ir0 v1 %h",
                     in_ready, out_valid, out_row, expand(4'h6));
        end
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_after: got v%b fd%b row%h ir%b want v0 fd0 row00 ir1",
                     out_valid, frame_done, out_row, in_ready);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        acc = 0;
        fd_pend = 0;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(N'($urandom));
        run_stream(100, 100, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        in_valid  = 1'b1;
        in_row    = 4'hF;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0 ||
            in_ready !== 1'b1 || out_row !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v%b l%b fd%b ir%b row%h want v0 l0 fd0 ir1 row00",
                     out_valid, out_last, frame_done, in_ready, out_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc = 0;
        fd_pend = 0;
        src.delete();
        for (int i = 0; i < N; i++) src.push_back(N'($urandom));
        run_stream(70, 70, cyc);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        acc       = 0;
        fd_pend   = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
